// File: rtl/line_aligner.sv
// line_aligner: FWFT pixel FIFO plus raster timing generator that locks
// each frame to an SOF-marked word and fills FILL on underflow.
//
// Ports:
//   video_clk, rst        pixel clock, async active-high reset
//   enable                run request (sampled at frame end and start)
//   in_data/in_sof/       input pixel stream; push on in_valid & in_ready
//   in_valid/in_ready
//   out_data/out_de/      registered raster outputs
//   out_hs/out_vs
//   underflow             sticky fill flag, cleared at each frame start
//   overflow              pulse when a word is dropped on a full FIFO
//   frame_err             pulse on SOF misalignment
//   frame_cnt             completed frames, wrapping
module line_aligner #(
    parameter int DATA_W     = 16,
    parameter int H_DISP     = 1280,
    parameter int H_FP       = 110,
    parameter int H_SYNC     = 40,
    parameter int H_BP       = 220,
    parameter int V_DISP     = 720,
    parameter int V_FP       = 5,
    parameter int V_SYNC     = 5,
    parameter int V_BP       = 20,
    parameter int FIFO_DEPTH = 2048,
    parameter int START_LVL  = 1280,
    parameter logic [DATA_W-1:0] FILL = '0
) (
    input  logic              video_clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_de,
    output logic              out_hs,
    output logic              out_vs,
    output logic              underflow,
    output logic              overflow,
    output logic              frame_err,
    output logic [15:0]       frame_cnt
);

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // FIFO storage: {sof, data}; pointers wrap naturally (power-of-two depth)
    logic [DATA_W:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full, empty, push, pop;
    logic              head_sof;
    logic [DATA_W-1:0] head_data;

    state_t            state_q, state_d;
    logic [HW-1:0]     h_q, h_d;
    logic [VW-1:0]     v_q, v_d;
    logic              relock_q, relock_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_de_q, out_de_d;
    logic              out_hs_q, out_hs_d;
    logic              out_vs_q, out_vs_d;
    logic              underflow_q, underflow_d;
    logic              overflow_q, overflow_d;
    logic              frame_err_q, frame_err_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;

    logic active, at_origin, line_end, frame_end, hs_pos, vs_pos;

    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign {head_sof, head_data} = mem_q[rd_ptr_q];

    assign active    = (h_q < HW'(H_DISP)) && (v_q < VW'(V_DISP));
    assign at_origin = (h_q == '0) && (v_q == '0);
    assign line_end  = (h_q == HW'(H_TOTAL - 1));
    assign frame_end = line_end && (v_q == VW'(V_TOTAL - 1));
    assign hs_pos    = (h_q >= HW'(H_DISP + H_FP)) &&
                       (h_q <  HW'(H_DISP + H_FP + H_SYNC));
    assign vs_pos    = (v_q >= VW'(V_DISP + V_FP)) &&
                       (v_q <  VW'(V_DISP + V_FP + V_SYNC));

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        v_d         = v_q;
        relock_d    = relock_q;
        pop         = 1'b0;
        out_data_d  = '0;
        out_de_d    = 1'b0;
        out_hs_d    = 1'b0;
        out_vs_d    = 1'b0;
        underflow_d = underflow_q;
        overflow_d  = in_valid && full;
        frame_err_d = 1'b0;
        frame_cnt_d = frame_cnt_q;

        unique case (state_q)
            IDLE: begin
                h_d      = '0;
                v_d      = '0;
                relock_d = 1'b0;
                // Drain junk until an SOF word sits at the head
                if (!empty && !head_sof) begin
                    pop = 1'b1;
                end else if (!empty && enable &&
                             count_q >= CW'(START_LVL)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (at_origin) begin
                    underflow_d = 1'b0;
                end
                // A non-SOF head at the frame origin means we lost lock;
                // an empty head here is just an underflow.
                if (at_origin && !empty && !head_sof) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                    h_d         = '0;
                    v_d         = '0;
                end else begin
                    out_de_d = active;
                    out_hs_d = hs_pos;
                    out_vs_d = vs_pos;
                    if (active) begin
                        if (empty) begin
                            out_data_d  = FILL;
                            underflow_d = 1'b1;
                        end else begin
                            pop        = 1'b1;
                            out_data_d = head_data;
                            if (head_sof && !at_origin) begin
                                frame_err_d = 1'b1;
                                relock_d    = 1'b1;
                            end
                        end
                    end
                    if (line_end) begin
                        h_d = '0;
                        v_d = v_q + VW'(1);
                    end else begin
                        h_d = h_q + HW'(1);
                    end
                    if (frame_end) begin
                        v_d         = '0;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        if (!enable || relock_q) begin
                            state_d  = IDLE;
                            relock_d = 1'b0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge video_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_sof, in_data};
        end
    end

    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            h_q         <= '0;
            v_q         <= '0;
            relock_q    <= 1'b0;
            out_data_q  <= '0;
            out_de_q    <= 1'b0;
            out_hs_q    <= 1'b0;
            out_vs_q    <= 1'b0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            h_q         <= h_d;
            v_q         <= v_d;
            relock_q    <= relock_d;
            out_data_q  <= out_data_d;
            out_de_q    <= out_de_d;
            out_hs_q    <= out_hs_d;
            out_vs_q    <= out_vs_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_de    = out_de_q;
    assign out_hs    = out_hs_q;
    assign out_vs    = out_vs_q;
    assign underflow = underflow_q;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_line_aligner.sv
// tb_line_aligner: scoreboard bench for line_aligner with a queue-based
// reference model of the FIFO and a linear raster position.
module tb_line_aligner;

    localparam int HD = 8, HF = 2, HS = 2, HB = 2;
    localparam int VD = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int DEPTH = 16;
    localparam int START = 8;
    localparam logic [15:0] FILLV = 16'hDEAD;

    typedef struct packed {
        logic        sof;
        logic [15:0] data;
    } word_t;

    logic        video_clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_sof = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_de, out_hs, out_vs;
    logic        underflow, overflow, frame_err;
    logic [15:0] frame_cnt;

    line_aligner #(
        .DATA_W(16), .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .FIFO_DEPTH(DEPTH), .START_LVL(START), .FILL(FILLV)
    ) dut (
        .video_clk(video_clk), .rst(rst), .enable(enable),
        .in_data(in_data), .in_sof(in_sof), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_de(out_de),
        .out_hs(out_hs), .out_vs(out_vs), .underflow(underflow),
        .overflow(overflow), .frame_err(frame_err),
        .frame_cnt(frame_cnt)
    );

    always #5 video_clk = ~video_clk;

    int n_tests = 0;
    int n_fail = 0;
    int err_pulses = 0;
    int ov_pulses = 0;

    // Reference model state
    word_t       m_fifo[$];
    logic [15:0] sb_q[$];
    bit          m_run = 0, m_relock = 0;
    int          m_t = 0;
    bit          e_de = 0, e_hs = 0, e_vs = 0;
    bit          e_uf = 0, e_ov = 0, e_err = 0;
    logic [15:0] e_fcnt = '0;

    word_t hd;
    int    mh, mv;
    bit    have, full_now, act;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, got, exp, $time);
        end
    endtask

    always @(posedge video_clk or posedge rst) begin
        if (rst) begin
            m_fifo.delete();
            sb_q.delete();
            m_run = 0; m_relock = 0; m_t = 0;
            e_de = 0; e_hs = 0; e_vs = 0;
            e_uf = 0; e_ov = 0; e_err = 0;
            e_fcnt = '0;
        end else begin
            have     = m_fifo.size() > 0;
            full_now = m_fifo.size() >= DEPTH;
            if (have) hd = m_fifo[0];
            e_ov = in_valid && full_now;
            e_err = 0; e_de = 0; e_hs = 0; e_vs = 0;
            if (!m_run) begin
                if (have && !hd.sof)
                    void'(m_fifo.pop_front());
                else if (have && enable && m_fifo.size() >= START) begin
                    m_run = 1;
                    m_t = 0;
                end
            end else begin
                mh = m_t % HT;
                mv = m_t / HT;
                if (m_t == 0) e_uf = 0;
                if (m_t == 0 && have && !hd.sof) begin
                    e_err = 1;
                    m_run = 0;
                end else begin
                    act  = (mh < HD) && (mv < VD);
                    e_de = act;
                    e_hs = (mh >= HD + HF) && (mh < HD + HF + HS);
                    e_vs = (mv >= VD + VF) && (mv < VD + VF + VS);
                    if (act) begin
                        if (have) begin
                            void'(m_fifo.pop_front());
                            sb_q.push_back(hd.data);
                            if (hd.sof && m_t != 0) begin
                                e_err = 1;
                                m_relock = 1;
                            end
                        end else begin
                            sb_q.push_back(FILLV);
                            e_uf = 1;
                        end
                    end
                    if (m_t == HT * VT - 1) begin
                        e_fcnt = e_fcnt + 16'd1;
                        m_t = 0;
                        if (!enable || m_relock) begin
                            m_run = 0;
                            m_relock = 0;
                        end
                    end else begin
                        m_t++;
                    end
                end
            end
            if (in_valid && !full_now)
                m_fifo.push_back({in_sof, in_data});
        end
    end

    // Monitor: compare registered outputs away from the active edge
    always @(negedge video_clk) begin
        logic [15:0] exp_px;
        chk("de", out_de, e_de);
        chk("hs", out_hs, e_hs);
        chk("vs", out_vs, e_vs);
        chk("underflow", underflow, e_uf);
        chk("overflow", overflow, e_ov);
        chk("frame_err", frame_err, e_err);
        chk("frame_cnt", frame_cnt, e_fcnt);
        chk("in_ready", in_ready, m_fifo.size() < DEPTH);
        if (frame_err) err_pulses++;
        if (overflow) ov_pulses++;
        if (out_de) begin
            if (sb_q.size() == 0) begin
                chk("pixel_unexpected", 1, 0);
            end else begin
                exp_px = sb_q.pop_front();
                chk("pixel", out_data, exp_px);
            end
        end
    end

    task automatic idle_in();
        @(negedge video_clk);
        in_valid = 0;
        in_sof = 0;
    endtask

    task automatic send(input logic sof, input logic [15:0] d);
        bit done = 0;
        int guard = 0;
        while (!done) begin
            @(negedge video_clk);
            if (in_ready) begin
                in_valid = 1;
                in_sof = sof;
                in_data = d;
                done = 1;
            end else begin
                in_valid = 0;
                guard++;
                if (guard > 2000) begin
                    chk("send_timeout", 1, 0);
                    done = 1;
                end
            end
        end
    endtask

    task automatic push_frame(input int base, input int n, input bit sof0,
                              input int stall_after, input int stall_len,
                              input bit rnd);
        for (int i = 0; i < n; i++) begin
            send(sof0 && i == 0, rnd ? 16'($urandom) : 16'(base + i));
            if (i == stall_after)
                repeat (stall_len) idle_in();
            else if (rnd && $urandom_range(0, 3) == 0)
                idle_in();
        end
        idle_in();
    endtask

    task automatic wait_idle(input int lim);
        int k = 0;
        while ((m_run || m_fifo.size() != 0 || out_de) && k < lim) begin
            @(negedge video_clk);
            k++;
        end
        chk("idle_timeout", k >= lim, 0);
        repeat (3) @(negedge video_clk);
    endtask

    initial begin
        repeat (3) @(negedge video_clk);
        chk("rst_de", out_de, 0);
        chk("rst_data", out_data, 0);
        chk("rst_hs_vs", {out_hs, out_vs}, 0);
        chk("rst_flags", {underflow, overflow, frame_err}, 0);
        chk("rst_fcnt", frame_cnt, 0);
        chk("rst_ready", in_ready, 1);
        rst = 0;

        // Nominal frame
        enable = 1;
        push_frame(0, 32, 1, -1, 0, 0);
        enable = 0;
        wait_idle(400);
        chk("nominal_fcnt", frame_cnt, 1);
        chk("nominal_uf", underflow, 0);

        // Junk ahead of SOF
        err_pulses = 0;
        enable = 1;
        for (int i = 0; i < 3; i++) send(0, 16'(900 + i));
        push_frame(0, 32, 1, -1, 0, 0);
        enable = 0;
        wait_idle(400);
        chk("junk_fcnt", frame_cnt, 2);
        chk("junk_err", err_pulses, 0);

        // Input stall causes underflow fill
        enable = 1;
        push_frame(0, 32, 1, 11, 20, 0);
        enable = 0;
        wait_idle(400);
        chk("uf_sticky", underflow, 1);
        chk("uf_fcnt", frame_cnt, 3);

        // Overflow while held idle
        ov_pulses = 0;
        for (int i = 0; i < 17; i++) begin
            @(negedge video_clk);
            if (i == 16) chk("ov_ready_low", in_ready, 0);
            in_valid = 1;
            in_sof = (i == 0);
            in_data = 16'(200 + i);
        end
        idle_in();
        repeat (2) @(negedge video_clk);
        chk("ov_pulses", ov_pulses, 1);
        enable = 1;
        begin
            int k = 0;
            while (!m_run && k < 50) begin
                @(negedge video_clk);
                k++;
            end
            chk("ov_start_timeout", k >= 50, 0);
        end
        enable = 0;
        wait_idle(400);
        chk("ov_fcnt", frame_cnt, 4);

        // Misaligned next frame, then relock
        err_pulses = 0;
        enable = 1;
        push_frame(300, 32, 1, -1, 0, 0);
        push_frame(400, 10, 0, -1, 0, 0);
        push_frame(500, 32, 1, -1, 0, 0);
        enable = 0;
        wait_idle(600);
        chk("mis_err", err_pulses, 1);
        chk("mis_fcnt", frame_cnt, 6);

        // Randomised back-to-back frames with gaps
        enable = 1;
        for (int f = 0; f < 3; f++) push_frame(0, 32, 1, -1, 0, 1);
        enable = 0;
        wait_idle(1000);

        // Reset mid-line at h=5, v=2
        enable = 1;
        fork
            push_frame(100, 32, 1, -1, 0, 0);
            begin
                int k = 0;
                while (!(m_run && m_t == 2 * HT + 5) && k < 500) begin
                    @(posedge video_clk);
                    #1;
                    k++;
                end
                chk("rst_pos_timeout", k >= 500, 0);
                rst = 1;
                #1;
                chk("mid_rst_de", out_de, 0);
                chk("mid_rst_data", out_data, 0);
                chk("mid_rst_fcnt", frame_cnt, 0);
                chk("mid_rst_uf", underflow, 0);
                @(negedge video_clk);
                @(negedge video_clk);
                rst = 0;
                chk("mid_rst_ready", in_ready, 1);
            end
        join
        enable = 0;
        wait_idle(400);

        chk("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
